// File: rtl/bk_adder_pkg.sv
// Shared types and constants for the byte-serial Brent-Kung adder controller.
package bk_adder_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bk_adder8_core.sv
// Combinational 8-bit Brent-Kung adder; cin is folded into bit 0 generate.
module bk_adder8_core
  import bk_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [7:0] p, g, gc;
  logic [3:0] p1, g1;
  logic [1:0] p2, g2;
  logic [8:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pg
      assign p[gi] = x[gi] ^ y[gi];
      if (gi == 0) begin : g_b0
        assign g[gi] = (x[gi] & y[gi]) | (p[gi] & cin);
      end else begin : g_bn
        assign g[gi] = x[gi] & y[gi];
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_lvl1
      assign g1[gi] = g[2*gi+1] | (p[2*gi+1] & g[2*gi]);
      assign p1[gi] = p[2*gi+1] & p[2*gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl2
      assign g2[gi] = g1[2*gi+1] | (p1[2*gi+1] & g1[2*gi]);
      assign p2[gi] = p1[2*gi+1] & p1[2*gi];
    end
  endgenerate

  // Up-sweep gives group carries at bits 1,3,7; down-sweep fills the rest.
  assign gc[0] = g[0];
  assign gc[1] = g1[0];
  assign gc[3] = g2[0];
  assign gc[7] = g2[1] | (p2[1] & g2[0]);
  assign gc[5] = g1[2] | (p1[2] & gc[3]);
  assign gc[2] = g[2] | (p[2] & gc[1]);
  assign gc[4] = g[4] | (p[4] & gc[3]);
  assign gc[6] = g[6] | (p[6] & gc[5]);

  assign c = {gc, cin};

  generate
    for (gi = 0; gi < 8; gi++) begin : g_sum
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[8];

endmodule

// File: rtl/bk_seq_adder32_ctrl.sv
// Byte-serial adder: one shared 8-bit Brent-Kung slice per cycle, LSB first.
// Optional subtract mode enabled by macro BK_SEQ_ADDER_SUBTRACT_EN.
module bk_seq_adder32_ctrl
  import bk_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*NBYTES-1:0]   a,
  input  logic [SLICE_W*NBYTES-1:0]   b,
`ifdef BK_SEQ_ADDER_SUBTRACT_EN
  input  logic                        sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*NBYTES:0]     sum
);

  localparam int W     = SLICE_W * NBYTES;
  localparam int CNT_W = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                carry_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [W-1:0]        a_reg, b_reg;
  logic [W:0]          sum_reg;
  logic [SLICE_W-1:0]  x_slice, y_slice, s_slice;
  logic                cout;

`ifdef BK_SEQ_ADDER_SUBTRACT_EN
  logic sub_reg;
  assign y_slice = b_reg[cnt_reg*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_reg}};
`else
  assign y_slice = b_reg[cnt_reg*SLICE_W +: SLICE_W];
`endif
  assign x_slice = a_reg[cnt_reg*SLICE_W +: SLICE_W];

  bk_adder8_core u_core (
    .x    (x_slice),
    .y    (y_slice),
    .cin  (carry_reg),
    .s    (s_slice),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
`ifdef BK_SEQ_ADDER_SUBTRACT_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= CALC;
`ifdef BK_SEQ_ADDER_SUBTRACT_EN
            sub_reg      <= sub;
            carry_reg    <= sub;
`else
            carry_reg    <= 1'b0;
`endif
          end
        end
        CALC: begin
          sum_reg[cnt_reg*SLICE_W +: SLICE_W] <= s_slice;
          carry_reg <= cout;
          if (cnt_reg == CNT_LAST) begin
            sum_reg[W]    <= cout;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;

endmodule

// File: tb/tb_bk_seq_adder32_ctrl.sv
// Scoreboard bench for bk_seq_adder32_ctrl (NBYTES=4); subtract cases run
// only when BK_SEQ_ADDER_SUBTRACT_EN is defined.
module tb_bk_seq_adder32_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct {
    logic [W:0] exp_sum;
    int         acc_cyc;
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   sum;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bk_seq_adder32_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef BK_SEQ_ADDER_SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic; subtraction carry-out means no borrow.
  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic do_sub);
    logic [W:0] r;
    if (do_sub) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  // Present an operation, wait for acceptance, push the expectation.
  task automatic issue(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic do_sub);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = do_sub;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    end else begin
      @(posedge clk);
      #1;
      e.exp_sum = ref_model(x, y, do_sub);
      e.acc_cyc = cyc;
      e.name    = name;
      last_acc  = cyc;
      sb_q.push_back(e);
      $display("issue %s a=0x%08h b=0x%08h sub=%0d accepted at cycle %0d", name, x, y, do_sub, cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_drain(input int budget);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: records the rise of out_valid and compares on each handshake.
  int   rise_cyc = 0;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(sum), 64'd0);
          check("unexpected_output_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_sum"}, 64'(sum), 64'(e.exp_sum));
          check({e.name, "_latency"}, 64'(rise_cyc + 1 - e.acc_cyc), 64'(NB + 1));
          $display("result %s sum=0x%09h exp=0x%09h", e.name, sum, e.exp_sum);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held;
    int         prev;
    int         guard;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_drain(20);
    issue("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_drain(20);
    issue("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_drain(20);

    // Hold in DONE with out_ready low; a new request must be ignored.
    out_ready = 1'b0;
    issue("hold", 32'h1234_5678, 32'h8765_4321, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("hold_reach_done", 64'(out_valid), 64'd1);
    held = sum;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      #1;
      check("hold_sum", 64'(sum), 64'(held));
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(20);

    // Abort mid-calculation once the slice counter has reached 2.
    issue("aborted", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    while (cyc < last_acc + 2) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      check("abort_no_output", 64'(out_valid), 64'd0);
    end
    issue("after_abort", 32'd7, 32'd9, 1'b0);
    wait_drain(20);

`ifdef BK_SEQ_ADDER_SUBTRACT_EN
    issue("sub_neg", 32'd5, 32'd7, 1'b1);
    wait_drain(20);
    issue("sub_pos", 32'd7, 32'd5, 1'b1);
    wait_drain(20);
    issue("sub_equal", 32'hCAFE_0000, 32'hCAFE_0000, 1'b1);
    wait_drain(20);
`endif

    // Back-to-back with out_ready high: accepts must be NB+2 cycles apart.
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue("b2b", $urandom, $urandom, 1'b0);
      if (prev >= 0) check("b2b_spacing", 64'(last_acc - prev), 64'(NB + 2));
      prev = last_acc;
    end
    wait_drain(20);

    // Random operations with random gaps and consumer stalls.
    for (int i = 0; i < 30; i++) begin
      logic do_sub;
`ifdef BK_SEQ_ADDER_SUBTRACT_EN
      do_sub = 1'($urandom_range(0, 1));
`else
      do_sub = 1'b0;
`endif
      out_ready = 1'($urandom_range(0, 3) != 0);
      issue("rand", $urandom, $urandom, do_sub);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      wait_drain(30);
    end

    check("final_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
